// File: rtl/uart_boot_loader.sv
// UART boot sequencer: sends a sync byte, receives a 4-byte little-endian
// size, streams the program into instruction memory as 32-bit words, then
// sends an ack byte and raises loaded.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   rx_ready/rdata/ferr - received byte strobe, byte, framing error
//   tx_busy           - transmitter busy
//   tx_start/sdata    - transmit strobe and byte
//   imem_we/addr/wd   - instruction memory word write
//   loaded/error      - sticky completion / abort flags
module uart_boot_loader #(
  parameter int          IMEM_ADDR_WIDTH = 15,
  parameter logic [7:0]  SYNC_BYTE       = 8'h99,
  parameter logic [7:0]  ACK_BYTE        = 8'haa
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx_ready,
  input  logic [7:0]                 rdata,
  input  logic                       ferr,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 sdata,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wd,
  output logic                       loaded,
  output logic                       error
);

  localparam int AW = IMEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_SYNC, S_SIZE, S_PROG, S_ACK, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    sdata_q, sdata_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [31:0]   size_q, size_d;
  logic [31:0]   word_q, word_d;

  logic          tx_ok;
  logic [31:0]   size_n;
  logic [31:0]   word_n;
  logic [AW:0]   nwords;
  logic [AW:0]   wcnt_inc;

  // UartTx reports busy one cycle late, so never start twice in a row.
  assign tx_ok    = !tx_busy && !tx_start_q;
  assign nwords   = size_q[AW+2:2];
  assign wcnt_inc = wcnt_q + 1'b1;

  always_comb begin
    size_n = size_q;
    size_n[{bcnt_q, 3'b000} +: 8] = rdata;
    word_n = word_q;
    word_n[{bcnt_q, 3'b000} +: 8] = rdata;
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    sdata_d    = sdata_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    size_d     = size_q;
    word_d     = word_q;
    unique case (state_q)
      S_SYNC: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          sdata_d    = SYNC_BYTE;
          state_d    = S_SIZE;
        end
      end
      S_SIZE: begin
        if (rx_ready) begin
          if (ferr) begin
            state_d = S_ERR;
          end else begin
            size_d = size_n;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (size_n[1:0] != 2'b00) begin
                state_d = S_ERR;
              end else if ((size_n >> 2) > (32'd1 << AW)) begin
                state_d = S_ERR;
              end else if (size_n == 32'd0) begin
                state_d = S_ACK;
              end else begin
                state_d = S_PROG;
                wcnt_d  = '0;
              end
            end
          end
        end
      end
      S_PROG: begin
        if (rx_ready) begin
          if (ferr) begin
            state_d = S_ERR;
          end else begin
            word_d = word_n;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              we_d   = 1'b1;
              addr_d = wcnt_q[AW-1:0];
              wd_d   = word_n;
              wcnt_d = wcnt_inc;
              if (wcnt_inc == nwords) state_d = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          sdata_d    = ACK_BYTE;
          state_d    = S_DONE;
        end
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_SYNC;
      tx_start_q <= 1'b0;
      sdata_q    <= 8'h00;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= 32'h0;
      bcnt_q     <= 2'd0;
      wcnt_q     <= '0;
      size_q     <= 32'h0;
      word_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      sdata_q    <= sdata_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      size_q     <= size_d;
      word_q     <= word_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign sdata     = sdata_q;
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign loaded    = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- CPU-side boot sequencer that drives the UartTx/UartRx pair inside Top.
- Announces readiness with a sync byte, receives a 4-byte little-endian program size, then receives the program byte stream, packs it into 32-bit words and writes them to instruction memory.
- Sends an ack byte when loading completes and hands control to the core via `loaded`.
- Counterpart of the simulation Server's 0x99 / size / program / 0xaa protocol.

Parameters:
- IMEM_ADDR_WIDTH, 15, instruction memory word-address width; capacity is 2^IMEM_ADDR_WIDTH words.
- SYNC_BYTE, 8'h99, byte transmitted to request a program.
- ACK_BYTE, 8'haa, byte transmitted after the last program word is written.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_ready  input  1  one-cycle pulse from UartRx: rdata is valid
- rdata  input  8  received byte
- ferr  input  1  UartRx framing error, sampled together with rx_ready
- tx_busy  input  1  UartTx busy
- tx_start  output  1  one-cycle pulse to UartTx
- sdata  output  8  byte to transmit; held stable while tx_start is high
- imem_we  output  1  instruction memory write enable, one-cycle pulse
- imem_addr  output  IMEM_ADDR_WIDTH  word address of the write
- imem_wd  output  32  write data
- loaded  output  1  program loaded and ack sent; sticky until reset
- error  output  1  load aborted; sticky until reset

Behaviour:
- Reset values:
  - tx_start=0, sdata=0, imem_we=0, imem_addr=0, imem_wd=0, loaded=0, error=0.
  - State=S_SYNC, byte counter=0, word counter=0, size register=0.
- Transmit rule:
  - tx_start is pulsed only when tx_busy=0 and tx_start was 0 in the previous cycle. This covers UartTx's one-cycle busy lag.
  - sdata is loaded in the same cycle tx_start goes high.
- S_SYNC:
  - On the first legal transmit cycle, pulse tx_start with sdata=SYNC_BYTE, then go to S_SIZE.
  - rx_ready arriving during S_SYNC is ignored.
- S_SIZE:
  - Each rx_ready shifts rdata into size[8*k+7:8*k], with k = 0..3 (byte 0 is the LSB).
  - After byte 3, evaluate the final size:
    - size[1:0]≠0 → S_ERR.
    - size>>2 > 2^IMEM_ADDR_WIDTH → S_ERR.
    - size==0 → S_ACK.
    - Otherwise → S_PROG with word counter=0.
- S_PROG:
  - Each rx_ready places rdata into word byte lane k (little-endian, k = 0..3).
  - On the cycle after lane 3 is received:
    - imem_we=1 for exactly one cycle.
    - imem_addr = word counter; imem_wd = assembled word.
    - Word counter increments.
  - Latency: rx_ready of the 4th byte at cycle N → imem_we at N+1.
  - When the written word is number size/4 - 1, go to S_ACK in that same write cycle.
  - The word counter is IMEM_ADDR_WIDTH+1 bits wide, so a full-capacity load does not wrap before the compare.
- S_ACK:
  - Pulse tx_start with sdata=ACK_BYTE under the transmit rule, then go to S_DONE.
- S_DONE:
  - loaded=1. All rx_ready pulses are ignored and no further writes occur.
- S_ERR:
  - error=1. No writes and no transmits occur. Exit only by reset.
- ferr=1 together with rx_ready in S_SIZE or S_PROG → S_ERR. The byte is discarded and no write is issued for a partial word.
- imem_we is never high outside S_PROG's write cycle.
- rx_ready in the write cycle itself is accepted as lane 0 of the next word. Any pulse rate is supported, including back-to-back.
- Reset mid-operation:
  - Aborts immediately.
  - Partially assembled words are discarded.
  - The sequence restarts at S_SYNC and sends SYNC_BYTE again.

Test Plan:
- Normal load:
  - Stimulus: after reset, tx_busy=0; send size bytes 08 00 00 00, then 78 56 34 12 EF BE AD DE.
  - Required: tx_start with 0x99 first.
  - Required: writes (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF), each one cycle after its 4th byte.
  - Required: tx_start with 0xAA, then loaded=1 and error=0.
- Zero size:
  - Stimulus: size 00 00 00 00.
  - Required: no imem_we; 0xAA transmitted; loaded=1.
- Bad size:
  - Stimulus: size 06 00 00 00 → error=1, no writes, no 0xAA.
  - Stimulus: size of (2^IMEM_ADDR_WIDTH+1)*4 → error=1, no writes.
- Framing error:
  - Stimulus: ferr=1 on the 3rd byte of word 1 of an 8-byte program.
  - Required: exactly one write (word 0); then error=1, loaded=0.
- Transmit backpressure:
  - Stimulus: hold tx_busy=1 for 200 cycles after reset.
  - Required: tx_start stays 0 throughout; 0x99 is sent exactly once after tx_busy falls.
  - Required: 0xAA is likewise delayed when tx_busy=1 at load end.
- Reset mid-load:
  - Stimulus: assert reset after 5 program bytes.
  - Required: all outputs return to reset values; 0x99 is re-sent; a fresh 4-byte load writes addr 0 correctly.
